// File: rtl/product_accumulator.sv
// Purpose : sums up to BLOCK_LEN unsigned products per block and presents the total.
// Latency : result valid the cycle after the final accepted beat; one bubble per block.
// Backpr. : in_ready drops while a result waits for out_ready or while clear is high.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   clear               flush current block and any pending result
//   in_valid/in_ready   product handshake (in_product, in_last = early block end)
//   out_valid/out_ready result handshake (out_sum, out_count, out_ovf)
//
// Build option: define PRODUCT_ACC_SAT_EN to saturate the sum on overflow instead
// of wrapping modulo 2^ACC_W. out_ovf is reported in both builds.
module product_accumulator #(
  parameter int PROD_W    = 32,
  parameter int ACC_W     = 40,
  parameter int BLOCK_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             beat;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [7:0]       cnt_inc;
  logic             block_end;
  logic [ACC_W-1:0] acc_upd;

  assign beat      = in_valid && in_ready;
  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
  assign carry     = sum_ext[ACC_W];
  assign cnt_inc   = cnt + 8'd1;
  assign block_end = (cnt_inc == 8'(BLOCK_LEN)) || in_last;

`ifdef PRODUCT_ACC_SAT_EN
  // Once the block has overflowed it stays pinned at all ones until it ends.
  assign acc_upd = (carry || ovf) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_upd = sum_ext[ACC_W-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else if (clear) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat && block_end) state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulator datapath
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ACCUM) begin
      if (beat) begin
        acc <= acc_upd;
        cnt <= cnt_inc;
        ovf <= ovf | carry;
      end
    end else if (out_ready) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  // Outputs: result fields are masked to zero outside DONE.
  always_comb begin
    in_ready  = (state == ACCUM) && !clear;
    out_valid = (state == DONE);
    out_sum   = (state == DONE) ? acc : '0;
    out_count = (state == DONE) ? cnt : '0;
    out_ovf   = (state == DONE) ? ovf : 1'b0;
  end

endmodule
